hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the PC enable and the IF/ID enable and flush controls. Drives the ID/EX bubble insert, which also determines what reaches the EX/MEM and MEM/WB registers.
- Detects load-use hazards and taken-branch/jump redirects.
- Sequences the multi-cycle mult/div unit (MDU) with an internal busy FSM. Younger HI/LO users stall until the result is ready.

Parameters:
- MDU_CYCLES, 32, cycles the MDU needs after issue before HI/LO are valid (legal range 2..63).
- CNT_W, 6, width of the MDU down-counter; must satisfy 2^CNT_W > MDU_CYCLES.
- PERF_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_jump  in  1  ID instruction is j/jal/jr/jalr (redirect resolved in ID)
- id_mdu_op  in  1  ID instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- ex_rt  in  5  destination rt of the instruction in EX
- ex_memread  in  1  EX instruction is a load (MemtoReg selects memory)
- ex_branch_taken  in  1  EX branch resolved taken this cycle
- ex_mdu_start  in  1  EX instruction issues a mult/div this cycle
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a NOP (instruction 0)
- idex_flush  out  1  ID/EX loads a bubble (RegWr=0, MemWr=0, MemRead=0)
- mdu_busy  out  1  MDU operation in flight
- mdu_done  out  1  one-cycle pulse when HI/LO become valid
- stall_cycles  out  PERF_W  count of cycles with pc_en=0, saturating

Behaviour:
- Control outputs (pc_en, ifid_en, ifid_flush, idex_flush) are combinational from the inputs and the registered FSM state. mdu_busy, mdu_done and stall_cycles are registered.
- Hazard terms:
  - load_use = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - mdu_hold = id_mdu_op & (state!=IDLE | ex_mdu_start). A DONE-state hold releases on the next cycle.
  - stall = load_use | mdu_hold.
- Priority, highest first:
  - (1) reset: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
  - (2) ex_branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1. Stall is ignored because the stalled instruction is squashed.
  - (3) stall: pc_en=0, ifid_en=0, ifid_flush=0, idex_flush=1.
  - (4) id_jump: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=0.
  - (5) default: pc_en=1, ifid_en=1, flushes 0.
- A jump under stall is not flushed; it re-evaluates when the stall clears.
- MDU FSM states are IDLE, BUSY and DONE. Reset state is IDLE with cnt=0.
  - IDLE: if ex_mdu_start then cnt<=MDU_CYCLES-1 and go to BUSY.
  - BUSY: cnt<=cnt-1. When cnt==1, go to DONE.
  - DONE: lasts one cycle, then IDLE. If ex_mdu_start is asserted in DONE, reload cnt and go to BUSY.
  - ex_mdu_start is ignored in BUSY. The upstream mdu_hold guarantees it cannot occur there; verification asserts this.
- Register outputs:
  - mdu_busy = 1 exactly in BUSY, registered.
  - mdu_done = 1 exactly in DONE.
  - Issue at edge N gives mdu_busy high from edge N+1 for MDU_CYCLES-1 cycles. mdu_done then pulses for one cycle, and HI/LO are readable by an mf* in ID during that pulse.
- stall_cycles increments on each clock where pc_en=0 and reset=0. It holds at 2^PERF_W-1.
- Reset of all registered outputs: mdu_busy=0, mdu_done=0, stall_cycles=0, state=IDLE.
- Reset mid-operation aborts the MDU sequence and returns to IDLE on the next edge.
- ex_rt==0 never causes a load-use stall.
- A simultaneous load-use hazard and mdu_hold produce one stall, and stall_cycles counts one cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - MDU state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - NOP_INSTR=32'h0;
  - REG_ZERO=5'd0.
- One natural sub-module, mdu_seq: the IDLE/BUSY/DONE FSM plus down-counter, with outputs state, mdu_busy and mdu_done.
- The hazard and priority logic stays in hazard_ctrl.

Test Plan:
- Load-use: lw writes $8 in EX (ex_memread=1, ex_rt=8), ID has id_rs=8 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Next cycle with ex_memread=0 -> normal operation; stall_cycles=1.
- Zero register: ex_memread=1, ex_rt=0, id_rs=0 -> no stall; pc_en=1.
- Branch over stall: load_use and ex_branch_taken both asserted -> pc_en=1, ifid_flush=1, idex_flush=1; stall_cycles unchanged.
- MDU timing with MDU_CYCLES=4: ex_mdu_start pulse at cycle 0, mfhi held in ID (id_mdu_op=1):
  - mdu_busy is high for cycles 1-3 and mdu_done pulses at cycle 4;
  - pc_en=0 for cycles 0-4 and returns to 1 at cycle 5;
  - stall_cycles=5.
- Back-to-back issue: ex_mdu_start during DONE -> FSM returns to BUSY with no IDLE cycle, and mdu_busy rises on the next edge.
- Reset mid-BUSY: assert reset at cycle 2 of an MDU op -> next edge gives mdu_busy=0, mdu_done=0, stall_cycles=0; all flushes are high while reset is held.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the hazard/stall control slice.
package pipe_pkg;

  // MDU sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

endpackage

// File: rtl/hazard_ctrl_mdu_seq.sv
// Multi-cycle mult/div sequencer: IDLE/BUSY/DONE FSM with a down-counter.
module mdu_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output mdu_state_t state,
  output logic       mdu_busy,
  output logic       mdu_done
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

  mdu_state_t       state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Next-state and counter update; start is ignored while BUSY
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          cnt_nxt   = CNT_LOAD;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered status flags (flags decoded from next state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mdu_busy <= 1'b0;
      mdu_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      mdu_busy <= (state_nxt == BUSY);
      mdu_done <= (state_nxt == DONE);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, MDU hold and redirect control.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_CYCLES = 32,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic              id_mdu_op,
  input  logic [4:0]        ex_rt,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  input  logic              ex_mdu_start,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] stall_cycles
);

  mdu_state_t state;
  logic       load_use, mdu_hold, stall;

  mdu_seq #(
    .MDU_CYCLES (MDU_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_seq (
    .clk      (clk),
    .reset    (reset),
    .start    (ex_mdu_start),
    .state    (state),
    .mdu_busy (mdu_busy),
    .mdu_done (mdu_done)
  );

  // Hazard detection terms
  always_comb begin
    load_use = ex_memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    mdu_hold = id_mdu_op && ((state != IDLE) || ex_mdu_start);
    stall    = load_use || mdu_hold;
  end

  // Prioritised pipeline control: reset > branch > stall > jump > run
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (reset || ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      ifid_flush = 1'b1;
    end
  end

  // Saturating count of cycles with the PC frozen
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_en && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_CYCLES=4, PERF_W=3).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jump, id_mdu_op;
  logic       ex_memread, ex_branch_taken, ex_mdu_start;
  logic       pc_en, ifid_en, ifid_flush, idex_flush;
  logic       mdu_busy, mdu_done;
  logic [2:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(
    .MDU_CYCLES (4),
    .CNT_W      (6),
    .PERF_W     (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .id_mdu_op       (id_mdu_op),
    .ex_rt           (ex_rt),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .ex_mdu_start    (ex_mdu_start),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .mdu_busy        (mdu_busy),
    .mdu_done        (mdu_done),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  // Issue must never coincide with a busy MDU
  always @(posedge clk) begin
    if (!reset && mdu_busy && ex_mdu_start)
      $error("ex_mdu_start asserted while MDU busy");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
    id_mdu_op = 1'b0; ex_rt = 5'd0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; ex_mdu_start = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 1111", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    n_checks++;
    if ({mdu_busy, mdu_done, stall_cycles} !== 5'b0) begin
      n_fail++; $display("FAIL reset_regs: busy=%b done=%b stall=%0d want 0 0 0", mdu_busy, mdu_done, stall_cycles);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1100) begin
      n_fail++; $display("FAIL run_ctrl: got %b want 1100", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b0001) begin
      n_fail++; $display("FAIL load_use_ctrl: got %b want 0001", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    tick();
    ex_memread = 1'b0;
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1100) begin
      n_fail++; $display("FAIL load_use_release: got %b want 1100", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    n_checks++;
    if (stall_cycles !== 3'd1) begin
      n_fail++; $display("FAIL load_use_count: got %0d want 1", stall_cycles);
    end
    // rt match only matters when rt is a source
    ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
    #1;
    n_checks++;
    if (pc_en !== 1'b1) begin
      n_fail++; $display("FAIL rt_unused: pc_en got %b want 1", pc_en);
    end
    id_uses_rt = 1'b1;
    #1;
    n_checks++;
    if (pc_en !== 1'b0) begin
      n_fail++; $display("FAIL rt_used: pc_en got %b want 0", pc_en);
    end
    idle_inputs();
    #1;
  endtask

  task automatic test_zero_reg();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    n_checks++;
    if ({pc_en, idex_flush} !== 2'b10) begin
      n_fail++; $display("FAIL zero_reg: pc_en/idex_flush got %b want 10", {pc_en, idex_flush});
    end
    tick();
    n_checks++;
    if (stall_cycles !== 3'd0) begin
      n_fail++; $display("FAIL zero_reg_count: got %0d want 0", stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_branch_over_stall();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL branch_ctrl: got %b want 1111", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    tick();
    n_checks++;
    if (stall_cycles !== 3'd0) begin
      n_fail++; $display("FAIL branch_count: got %0d want 0", stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_jump();
    apply_reset();
    id_jump = 1'b1;
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1110) begin
      n_fail++; $display("FAIL jump_ctrl: got %b want 1110", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    ex_memread = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b0001) begin
      n_fail++; $display("FAIL jump_stalled: got %b want 0001", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    idle_inputs();
  endtask

  task automatic test_mdu_timing();
    logic [4:0] exp_busy, exp_done, exp_pc;
    exp_busy = 5'b01110;   // bit k = cycle k
    exp_done = 5'b10000;
    exp_pc   = 5'b00000;
    apply_reset();
    id_mdu_op = 1'b1;
    ex_mdu_start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (pc_en !== exp_pc[k] || mdu_busy !== exp_busy[k] || mdu_done !== exp_done[k]) begin
        n_fail++;
        $display("FAIL mdu_cycle%0d: pc_en=%b busy=%b done=%b want %b %b %b",
                 k, pc_en, mdu_busy, mdu_done, exp_pc[k], exp_busy[k], exp_done[k]);
      end
      tick();
      ex_mdu_start = 1'b0;
    end
    #1;
    n_checks++;
    if (pc_en !== 1'b1 || mdu_busy !== 1'b0 || mdu_done !== 1'b0) begin
      n_fail++; $display("FAIL mdu_cycle5: pc_en=%b busy=%b done=%b want 1 0 0", pc_en, mdu_busy, mdu_done);
    end
    n_checks++;
    if (stall_cycles !== 3'd5) begin
      n_fail++; $display("FAIL mdu_count: got %0d want 5", stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    for (int k = 0; k < 20 && !mdu_done; k++) tick();
    n_checks++;
    if (mdu_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done_timeout: done=%b want 1", mdu_done);
    end
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    n_checks++;
    if (mdu_busy !== 1'b1 || mdu_done !== 1'b0) begin
      n_fail++; $display("FAIL b2b_reissue: busy=%b done=%b want 1 0", mdu_busy, mdu_done);
    end
    // second op must also take three busy cycles
    tick(); tick(); tick();
    n_checks++;
    if (mdu_busy !== 1'b0 || mdu_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_done: busy=%b done=%b want 0 1", mdu_busy, mdu_done);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    id_mdu_op = 1'b1;
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush} !== 4'b1111) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b want 1111", {pc_en, ifid_en, ifid_flush, idex_flush});
    end
    tick();
    n_checks++;
    if ({mdu_busy, mdu_done, stall_cycles} !== 5'b0) begin
      n_fail++; $display("FAIL midreset_regs: busy=%b done=%b stall=%0d want 0 0 0", mdu_busy, mdu_done, stall_cycles);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (pc_en !== 1'b1) begin
      n_fail++; $display("FAIL midreset_idle: pc_en got %b want 1", pc_en);
    end
    tick();
    n_checks++;
    if (mdu_busy !== 1'b0 || stall_cycles !== 3'd0) begin
      n_fail++; $display("FAIL midreset_after: busy=%b stall=%0d want 0 0", mdu_busy, stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_double_hazard();
    apply_reset();
    id_mdu_op = 1'b1; ex_mdu_start = 1'b1;
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    #1;
    n_checks++;
    if (pc_en !== 1'b0) begin
      n_fail++; $display("FAIL double_ctrl: pc_en got %b want 0", pc_en);
    end
    tick();
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cycles !== 3'd1) begin
      n_fail++; $display("FAIL double_count: got %0d want 1", stall_cycles);
    end
    for (int k = 0; k < 20 && !mdu_done; k++) tick();
    tick();
  endtask

  task automatic test_saturate();
    apply_reset();
    ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    for (int k = 0; k < 9; k++) tick();
    n_checks++;
    if (stall_cycles !== 3'd7) begin
      n_fail++; $display("FAIL saturate: got %0d want 7", stall_cycles);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_over_stall();
    test_jump();
    test_mdu_timing();
    test_back_to_back();
    test_reset_mid_busy();
    test_double_hazard();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
